// File: rtl/alu_seq_unit.sv
// Sequenced ALU: single-cycle logic/arith ops plus W-cycle Booth multiply and
// restoring divide, with Y operand register and Z result registers.
module alu_seq_unit #(
   parameter int W = 32
) (
   input  logic         clock,
   input  logic         clear,
   input  logic [W-1:0] bus_in,
   input  logic         ry_in,
   input  logic         start,
   input  logic [3:0]   opcode,
   output logic [W-1:0] z_lo,
   output logic [W-1:0] z_hi,
   output logic         busy,
   output logic         done,
   output logic         div_by_zero
);
   localparam int SW = $clog2(W);
   localparam int CW = SW + 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MUL  = 2'd1;
   localparam logic [1:0] ST_DIV  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   logic [1:0]    state_reg;
   logic [W-1:0]  y_reg, a_reg, b_reg, z_lo_reg, z_hi_reg;
   logic          dbz_reg;
   logic [CW-1:0] cnt_reg;
   // hi_reg/lo_reg: Booth accumulator/multiplier, or divide remainder/quotient
   logic [W:0]    hi_reg;
   logic [W-1:0]  lo_reg;
   logic          qm1_reg;

   function automatic logic [W-1:0] mag(input logic [W-1:0] v);
      mag = v[W-1] ? -v : v;
   endfunction

   logic [SW-1:0] sh;
   logic [CW-1:0] inv_sh;
   logic [W-1:0]  alu_lo;

   assign sh     = bus_in[SW-1:0];
   assign inv_sh = CW'(W) - {1'b0, sh};

   always_comb begin
      alu_lo = '0;
      case (opcode)
         4'd0:    alu_lo = y_reg + bus_in;
         4'd1:    alu_lo = y_reg - bus_in;
         4'd2:    alu_lo = y_reg & bus_in;
         4'd3:    alu_lo = y_reg | bus_in;
         4'd4:    alu_lo = y_reg >> sh;
         4'd5:    alu_lo = $signed(y_reg) >>> sh;
         4'd6:    alu_lo = y_reg << sh;
         // shifting by W yields zero, so sh=0 rotates cleanly
         4'd7:    alu_lo = (y_reg >> sh) | (y_reg << inv_sh);
         4'd8:    alu_lo = (y_reg << sh) | (y_reg >> inv_sh);
         4'd11:   alu_lo = -bus_in;
         4'd12:   alu_lo = ~bus_in;
         default: alu_lo = '0;
      endcase
   end

   // One Booth step; accumulator is W+1 bits so subtracting the most-negative A cannot overflow
   logic [W:0]   m_ext, booth_sum, booth_hi;
   logic [W-1:0] booth_lo;

   always_comb begin
      m_ext = {a_reg[W-1], a_reg};
      case ({lo_reg[0], qm1_reg})
         2'b01:   booth_sum = hi_reg + m_ext;
         2'b10:   booth_sum = hi_reg - m_ext;
         default: booth_sum = hi_reg;
      endcase
      booth_hi = {booth_sum[W], booth_sum[W:1]};
      booth_lo = {booth_sum[0], lo_reg[W-1:1]};
   end

   logic [W:0]   div_shift;
   logic         div_ge;
   logic [W-1:0] b_mag, rem_next, quo_next, quo_fix, rem_fix;

   always_comb begin
      div_shift = {hi_reg[W-1:0], lo_reg[W-1]};
      b_mag     = mag(b_reg);
      div_ge    = div_shift >= {1'b0, b_mag};
      rem_next  = div_ge ? (div_shift[W-1:0] - b_mag) : div_shift[W-1:0];
      quo_next  = {lo_reg[W-2:0], div_ge};
      // most-negative / -1 naturally wraps back to most-negative here
      quo_fix   = (a_reg[W-1] ^ b_reg[W-1]) ? -quo_next : quo_next;
      rem_fix   = a_reg[W-1] ? -rem_next : rem_next;
   end

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state_reg <= ST_IDLE;
         y_reg     <= '0;
         a_reg     <= '0;
         b_reg     <= '0;
         z_lo_reg  <= '0;
         z_hi_reg  <= '0;
         dbz_reg   <= 1'b0;
         cnt_reg   <= '0;
         hi_reg    <= '0;
         lo_reg    <= '0;
         qm1_reg   <= 1'b0;
      end else begin
         if (ry_in)
            y_reg <= bus_in;
         case (state_reg)
            ST_IDLE: begin
               if (start) begin
                  a_reg   <= y_reg;
                  b_reg   <= bus_in;
                  dbz_reg <= 1'b0;
                  if (opcode == 4'd9) begin
                     hi_reg    <= '0;
                     lo_reg    <= bus_in;
                     qm1_reg   <= 1'b0;
                     cnt_reg   <= CW'(W);
                     state_reg <= ST_MUL;
                  end else if (opcode == 4'd10) begin
                     if (bus_in == '0) begin
                        z_lo_reg  <= '1;
                        z_hi_reg  <= y_reg;
                        dbz_reg   <= 1'b1;
                        state_reg <= ST_DONE;
                     end else begin
                        hi_reg    <= '0;
                        lo_reg    <= mag(y_reg);
                        cnt_reg   <= CW'(W);
                        state_reg <= ST_DIV;
                     end
                  end else begin
                     z_lo_reg  <= alu_lo;
                     z_hi_reg  <= '0;
                     state_reg <= ST_DONE;
                  end
               end
            end
            ST_MUL: begin
               hi_reg  <= booth_hi;
               lo_reg  <= booth_lo;
               qm1_reg <= lo_reg[0];
               cnt_reg <= cnt_reg - 1'b1;
               if (cnt_reg == CW'(1)) begin
                  z_hi_reg  <= booth_hi[W-1:0];
                  z_lo_reg  <= booth_lo;
                  state_reg <= ST_DONE;
               end
            end
            ST_DIV: begin
               hi_reg  <= {1'b0, rem_next};
               lo_reg  <= quo_next;
               cnt_reg <= cnt_reg - 1'b1;
               if (cnt_reg == CW'(1)) begin
                  z_lo_reg  <= quo_fix;
                  z_hi_reg  <= rem_fix;
                  state_reg <= ST_DONE;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign z_lo        = z_lo_reg;
   assign z_hi        = z_hi_reg;
   assign busy        = (state_reg == ST_MUL) || (state_reg == ST_DIV);
   assign done        = (state_reg == ST_DONE);
   assign div_by_zero = dbz_reg;

endmodule
